// File: rtl/seven_segment_scan_if.sv
// Bus bundle for seven_segment_scan.
//   i_disp_val   : hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   i_dp_in      : decimal point request per digit, 1 = lit
//   i_load       : capture i_disp_val/i_dp_in into the shadow register
//   i_blank_lz   : 1 = suppress leading zeros
//   i_brightness : duty level, 0 = dimmest lit, 15 = full
//   o_segments   : segments g..a (bit 6 = g), active-low
//   o_dp_out     : decimal point, active-low
//   o_digit_sel  : one-hot or all-zero digit enables, active-high
//   o_frame_done : one-cycle pulse at the end of the last digit slot
// master drives the inputs (host side), slave is the display scanner.
interface seven_segment_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] i_disp_val;
  logic [DIGITS-1:0]   i_dp_in;
  logic                i_load;
  logic                i_blank_lz;
  logic [3:0]          i_brightness;
  logic [6:0]          o_segments;
  logic                o_dp_out;
  logic [DIGITS-1:0]   o_digit_sel;
  logic                o_frame_done;

  modport master (
    output i_disp_val, i_dp_in, i_load, i_blank_lz, i_brightness,
    input  o_segments, o_dp_out, o_digit_sel, o_frame_done
  );

  modport slave (
    input  i_disp_val, i_dp_in, i_load, i_blank_lz, i_brightness,
    output o_segments, o_dp_out, o_digit_sel, o_frame_done
  );
endinterface

// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment display scanner with double-buffered content,
// per-slot blanking dead time, 16-level brightness and leading-zero blanking.
//   i_clk : sole clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : seven_segment_scan_if.slave (display content in, drive signals out)
module seven_segment_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SLOT_CYCLES = 16384,
  parameter int unsigned DEAD_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  seven_segment_scan_if.slave bus
);

  localparam int unsigned   CW       = $clog2(SLOT_CYCLES);
  localparam int unsigned   DW       = $clog2(DIGITS);
  localparam int unsigned   STEP     = SLOT_CYCLES / 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

  typedef enum logic [1:0] {PH_DEAD, PH_ON, PH_OFF} phase_t;

  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_dig;
  logic [4*DIGITS-1:0] r_shadow;
  logic [DIGITS-1:0]   r_shadow_dp;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_active;
  logic [DIGITS-1:0]   r_active_dp;
  logic [3:0]          r_bright;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_sel;
  logic                r_frame_done;

  logic                w_slot_end;
  logic                w_frame_end;
  logic [3:0]          w_bright;
  logic [31:0]         w_on_lim;
  phase_t              w_phase;
  logic [3:0]          w_nib;
  logic                w_dp_bit;
  logic                w_zero_run;
  logic                w_blank;
  logic [DIGITS-1:0]   w_onehot;

  function automatic logic [6:0] f_enc(input logic [3:0] n);
    case (n)
      4'h0: f_enc = 7'h3F;  4'h1: f_enc = 7'h06;
      4'h2: f_enc = 7'h5B;  4'h3: f_enc = 7'h4F;
      4'h4: f_enc = 7'h66;  4'h5: f_enc = 7'h6D;
      4'h6: f_enc = 7'h7D;  4'h7: f_enc = 7'h07;
      4'h8: f_enc = 7'h7F;  4'h9: f_enc = 7'h67;
      4'hA: f_enc = 7'h77;  4'hB: f_enc = 7'h7C;
      4'hC: f_enc = 7'h39;  4'hD: f_enc = 7'h5E;
      4'hE: f_enc = 7'h79;  default: f_enc = 7'h71;
    endcase
  endfunction

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_dig == DIG_LAST);
  // Brightness is taken live at count 0 and held in r_bright for the slot.
  assign w_bright    = (r_cnt == '0) ? bus.i_brightness : r_bright;
  assign w_on_lim    = (32'(w_bright) + 32'd1) * STEP;
  assign w_onehot    = DIGITS'(1) << r_dig;

  always_comb begin
    w_phase = PH_OFF;
    if (32'(r_cnt) < DEAD_CYCLES)  w_phase = PH_DEAD;
    else if (32'(r_cnt) < w_on_lim) w_phase = PH_ON;
  end

  // Walk digits from the most significant down; w_zero_run stays set while
  // every nibble at or above the current position is zero.
  always_comb begin
    w_nib      = '0;
    w_dp_bit   = 1'b0;
    w_zero_run = 1'b1;
    w_blank    = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      w_zero_run = w_zero_run && (4'(r_active >> (4 * (DIGITS - 1 - k))) == 4'h0);
      if (r_dig == DW'(DIGITS - 1 - k)) begin
        w_nib    = 4'(r_active >> (4 * (DIGITS - 1 - k)));
        w_dp_bit = 1'(r_active_dp >> (DIGITS - 1 - k));
        w_blank  = bus.i_blank_lz && w_zero_run && (k != DIGITS - 1);
      end
    end
  end

  // Drive outputs trail the counter by one cycle, so frame_done is registered
  // too and lines up with the last output cycle of the frame; the active copy
  // happens on the same edge, so the next output cycle already shows it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_dig        <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_active     <= '0;
      r_active_dp  <= '0;
      r_bright     <= 4'hF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_sel        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_bright <= w_bright;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_dig <= (r_dig == DIG_LAST) ? '0 : r_dig + DW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_frame_end && r_pending) begin
        r_active    <= r_shadow;
        r_active_dp <= r_shadow_dp;
      end
      // A load on the boundary cycle wins over the clear and waits a frame.
      if (bus.i_load) begin
        r_shadow    <= bus.i_disp_val;
        r_shadow_dp <= bus.i_dp_in;
        r_pending   <= 1'b1;
      end else if (w_frame_end) begin
        r_pending   <= 1'b0;
      end

      r_frame_done <= w_frame_end;
      r_seg        <= w_blank ? 7'h7F : ~f_enc(w_nib);
      r_dp         <= ~w_dp_bit;
      r_sel        <= (w_phase == PH_ON) ? w_onehot : '0;
    end
  end

  assign bus.o_segments   = r_seg;
  assign bus.o_dp_out     = r_dp;
  assign bus.o_digit_sel  = r_sel;
  assign bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan (4 digits, 32-cycle slots, 1 dead cycle).
module tb_seven_segment_scan;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned SLOT   = 32;
  localparam int unsigned DEAD   = 1;
  localparam int unsigned FRAME  = DIGITS * SLOT;

  localparam logic [6:0] ENC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic       fd;
    logic [3:0] sel;
    logic       dp;
    logic [6:0] seg;
  } obs_t;

  localparam obs_t RST_OBS = '{fd: 1'b0, sel: 4'b0000, dp: 1'b1, seg: 7'h7F};

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t exp_q [$];
  obs_t cap_q [$];

  seven_segment_scan_if #(.DIGITS(DIGITS)) bus ();

  seven_segment_scan #(
    .DIGITS      (DIGITS),
    .SLOT_CYCLES (SLOT),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.fd  = bus.o_frame_done;
    o.sel = bus.o_digit_sel;
    o.dp  = bus.o_dp_out;
    o.seg = bus.o_segments;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("fd=%b sel=%b dp=%b seg=%h", o.fd, o.sel, o.dp, o.seg);
  endfunction

  // Push the 128 expected output cycles of one frame.
  task automatic expect_frame(input logic [15:0] val, input logic [3:0] dp,
                              input logic blz, input logic [3:0] br);
    obs_t        e;
    int unsigned d, p, lit_end;
    logic [3:0]  nib;
    logic        blank;
    lit_end = (int'(br) + 1) * SLOT / 16;
    for (int unsigned pos = 0; pos < FRAME; pos++) begin
      d     = pos / SLOT;
      p     = pos % SLOT;
      nib   = val[4*d +: 4];
      blank = blz && (d != 0) && ((val >> (4 * d)) == 16'h0);
      e.seg = blank ? 7'h7F : ~ENC[nib];
      e.dp  = ~dp[d];
      e.sel = (p >= DEAD && p < lit_end) ? (4'b0001 << d) : 4'b0000;
      e.fd  = (pos == FRAME - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic capture(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      cap_q.push_back(observe());
    end
  endtask

  task automatic load_pulse(input logic [15:0] val, input logic [3:0] dp);
    bus.i_disp_val = val;
    bus.i_dp_in    = dp;
    bus.i_load     = 1'b1;
    @(negedge clk);
    bus.i_load     = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a, e;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = observe();
      n_cmp++;
      if (a !== RST_OBS) begin
        n_fail++;
        $display("FAIL reset_outputs cyc %0d: got %s, expected %s", i, fmt(a), fmt(RST_OBS));
      end
    end
    rst = 1'b0;
    expect_frame(16'h0000, 4'h0, 1'b0, 4'hF);
    capture(FRAME);
    for (int i = 0; i < int'(FRAME); i++) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL reset_first_frame pos %0d: got %s, expected %s", i, fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_basic();
    obs_t a, e;
    expect_frame(16'h0000, 4'h0, 1'b0, 4'hF);
    expect_frame(16'h12AF, 4'h0, 1'b0, 4'hF);
    fork
      capture(2 * FRAME);
      begin
        repeat (10) @(negedge clk);
        load_pulse(16'h12AF, 4'h0);
      end
    join
    for (int i = 0; i < int'(2 * FRAME); i++) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL basic f%0d pos %0d: got %s, expected %s", i / FRAME, i % FRAME, fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_brightness();
    obs_t a, e;
    bus.i_brightness = 4'd3;
    expect_frame(16'h12AF, 4'h0, 1'b0, 4'd3);
    expect_frame(16'h0008, 4'b1010, 1'b0, 4'd3);
    fork
      capture(2 * FRAME);
      begin
        repeat (40) @(negedge clk);
        load_pulse(16'h0008, 4'b1010);
      end
    join
    for (int i = 0; i < int'(2 * FRAME); i++) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL brightness f%0d pos %0d: got %s, expected %s", i / FRAME, i % FRAME, fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_blank_lz();
    obs_t a, e;
    bus.i_brightness = 4'hF;
    bus.i_blank_lz   = 1'b1;
    expect_frame(16'h0008, 4'b1010, 1'b1, 4'hF);
    expect_frame(16'h0040, 4'b1000, 1'b1, 4'hF);
    expect_frame(16'h0000, 4'b0000, 1'b1, 4'hF);
    fork
      capture(3 * FRAME);
      begin
        repeat (20) @(negedge clk);
        load_pulse(16'h0040, 4'b1000);
        repeat (FRAME) @(negedge clk);
        load_pulse(16'h0000, 4'b0000);
      end
    join
    for (int i = 0; i < int'(3 * FRAME); i++) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL blank_lz f%0d pos %0d: got %s, expected %s", i / FRAME, i % FRAME, fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t a, e;
    bus.i_blank_lz = 1'b0;
    expect_frame(16'h0000, 4'h0, 1'b0, 4'hF);
    expect_frame(16'h2222, 4'h0, 1'b0, 4'hF);
    fork
      capture(2 * FRAME);
      begin
        repeat (15) @(negedge clk);
        load_pulse(16'h1111, 4'h0);
        repeat (60) @(negedge clk);
        load_pulse(16'h2222, 4'h0);
      end
    join
    for (int i = 0; i < int'(2 * FRAME); i++) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL back_to_back f%0d pos %0d: got %s, expected %s", i / FRAME, i % FRAME, fmt(a), fmt(e));
      end
    end
  endtask

  // Entered on the frame_done cycle: this load must skip the frame that starts next.
  task automatic test_load_on_frame_done();
    obs_t a, e;
    expect_frame(16'h2222, 4'h0, 1'b0, 4'hF);
    expect_frame(16'h5A5A, 4'b0110, 1'b0, 4'hF);
    fork
      capture(2 * FRAME);
      load_pulse(16'h5A5A, 4'b0110);
    join
    for (int i = 0; i < int'(2 * FRAME); i++) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL load_on_fd f%0d pos %0d: got %s, expected %s", i / FRAME, i % FRAME, fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t a, e;
    repeat (10) @(negedge clk);
    load_pulse(16'h7777, 4'hF);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a = observe();
      n_cmp++;
      if (a !== RST_OBS) begin
        n_fail++;
        $display("FAIL mid_reset_outputs cyc %0d: got %s, expected %s", i, fmt(a), fmt(RST_OBS));
      end
    end
    rst = 1'b0;
    expect_frame(16'h0000, 4'h0, 1'b0, 4'hF);
    expect_frame(16'h0000, 4'h0, 1'b0, 4'hF);
    capture(2 * FRAME);
    for (int i = 0; i < int'(2 * FRAME); i++) begin
      a = cap_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mid_reset f%0d pos %0d: got %s, expected %s", i / FRAME, i % FRAME, fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_frame_done_rate();
    int   pulses = 0;
    int   last   = 0;
    int   wide   = 0;
    logic prev   = 1'b1;
    logic fd;
    for (int i = 1; i <= int'(4 * FRAME); i++) begin
      @(negedge clk);
      fd = bus.o_frame_done;
      if (fd && prev) wide++;
      if (fd) begin
        pulses++;
        n_cmp++;
        if (i - last != int'(FRAME)) begin
          n_fail++;
          $display("FAIL fd_interval: got %0d cycles, expected %0d", i - last, FRAME);
        end
        last = i;
      end
      prev = fd;
    end
    n_cmp++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL fd_count: got %0d pulses, expected 4", pulses);
    end
    n_cmp++;
    if (wide != 0) begin
      n_fail++;
      $display("FAIL fd_width: got %0d multi-cycle pulses, expected 0", wide);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_disp_val   = '0;
    bus.i_dp_in      = '0;
    bus.i_load       = 1'b0;
    bus.i_blank_lz   = 1'b0;
    bus.i_brightness = 4'hF;
    test_reset();
    test_basic();
    test_brightness();
    test_blank_lz();
    test_back_to_back();
    test_load_on_frame_done();
    test_reset_mid_frame();
    test_frame_done_rate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
